// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared constants for the multicycle RV32 control path:
//   - major opcodes decoded by the control FSM
//   - ALUOp encoding (also consumed by the ALU control decoder)
//   - ALU operand mux select encodings
//   - 4-bit FSM state encodings (FETCH = 0, TRAP = 0xF)
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values that select the only supported OP-IMM / BRANCH forms
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // ALUOp handed to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // FSM state encodings
    typedef enum logic [3:0] {
        ST_FETCH    = 4'h0,
        ST_DECODE   = 4'h1,
        ST_EXEC_R   = 4'h2,
        ST_EXEC_I   = 4'h3,
        ST_WB_ALU   = 4'h4,
        ST_MEM_ADDR = 4'h5,
        ST_MEM_RD   = 4'h6,
        ST_WB_MEM   = 4'h7,
        ST_MEM_WR   = 4'h8,
        ST_BRANCH   = 4'h9,
        ST_TRAP     = 4'hF
    } state_t;

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_outdec
// Purely combinational decode of the control FSM state into datapath
// enables, memory requests and mux selects.
// Ports:
//   state      in   current FSM state
//   rst        in   reset; forces every output to 0 while high
//   mem_ready  in   memory completes access this cycle (gates FETCH writes)
//   zero       in   ALU zero flag (gates the beq PC write)
//   pc_write .. pc_source  out  datapath controls
// ---------------------------------------------------------------------------
module multicycle_ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       rst,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source
);

    // Everything defaults to 0 so that each state only lists what it drives.
    // Reset overrides the state decode, which is what lets an in-flight
    // memory request drop the moment rst rises, without waiting for a clock.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        pc_source  = 1'b0;

        if (!rst) begin
            case (state)
                // PC+4 is computed while the instruction is read; IR and PC
                // only latch on the cycle the memory actually returns data.
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                // Speculatively form the branch target into ALUOut.
                ST_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                ST_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_RTYPE;
                end
                ST_EXEC_I, ST_MEM_ADDR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                ST_WB_ALU: begin
                    reg_write = 1'b1;
                end
                ST_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                // rs1 - rs2 sets zero; the target already sits in ALUOut.
                ST_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    pc_source = 1'b1;
                    pc_write  = zero;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore control FSM for the multicycle RV32 core: FETCH, DECODE, EXECUTE,
// MEMORY and WRITEBACK sequencing, memory wait-state stalls, an absorbing
// trap on unsupported opcodes and a retired-instruction counter.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   opcode, funct3      instruction fields from IR
//   zero                ALU zero flag
//   mem_ready           memory completes access this cycle
//   pc_write .. pc_source  datapath controls (see multicycle_ctrl_outdec)
//   illegal             sticky illegal-instruction flag
//   instret             retired-instruction count (wraps)
//   state_dbg           current state encoding
// ---------------------------------------------------------------------------
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 pc_source,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state_dbg
);

    state_t                 state_q;
    state_t                 state_d;
    logic                   illegal_q;
    logic [INSTRET_W-1:0]   instret_q;
    logic                   retire;

    // Next-state logic. opcode is only consulted in DECODE and MEM_ADDR,
    // where IR already holds the current instruction and stays stable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OPC_RTYPE)
                    state_d = ST_EXEC_R;
                else if (opcode == OPC_OPIMM && funct3 == F3_ADDI)
                    state_d = ST_EXEC_I;
                else if (opcode == OPC_LOAD || opcode == OPC_STORE)
                    state_d = ST_MEM_ADDR;
                else if (opcode == OPC_BRANCH && funct3 == F3_BEQ)
                    state_d = ST_BRANCH;
                else
                    state_d = ST_TRAP;
            end
            ST_EXEC_R:   state_d = ST_WB_ALU;
            ST_EXEC_I:   state_d = ST_WB_ALU;
            ST_WB_ALU:   state_d = ST_FETCH;
            ST_MEM_ADDR: state_d = (opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
            ST_WB_MEM:   state_d = ST_FETCH;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            // Unused encodings are treated as a corrupted state and trap.
            default:     state_d = ST_TRAP;
        endcase
    end

    // An instruction retires on the edge that leaves its last state; a store
    // is only finished once the memory accepts the write.
    assign retire = (state_q == ST_WB_ALU) ||
                    (state_q == ST_WB_MEM) ||
                    (state_q == ST_BRANCH) ||
                    (state_q == ST_MEM_WR && mem_ready);

    // State register, sticky illegal flag and retire counter. illegal is set
    // on the edge entering TRAP so it is already high in the first TRAP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_TRAP)
                illegal_q <= 1'b1;
            if (retire)
                instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    multicycle_ctrl_outdec u_outdec (
        .state      (state_q),
        .rst        (rst),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source)
    );

    assign illegal   = illegal_q;
    assign instret   = instret_q;
    assign state_dbg = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore FSM sequencing the multicycle RV32 core through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and generates the 2-bit ALUOp consumed by the ALU control decoder (00 ADD, 01 SUB, 10 R-type by funct3/funct7). It also stalls on memory wait states, traps illegal opcodes and counts retired instructions.

Parameters:
INSTRET_W, 32, width of retired-instruction counter
OPC_* / ALUOP_* / ST_*, package constants, not overridable

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  PC register write enable
ir_write  out  1  IR and old-PC register write enable
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = imm
alu_op  out  2  00 ADD, 01 SUB, 10 R-type
pc_source  out  1  0 = ALU result, 1 = ALUOut
illegal  out  1  sticky illegal-instruction flag
instret  out  INSTRET_W  retired-instruction count
state_dbg  out  4  current state encoding

Behaviour:
- Single clock; rst asynchronous, active-high. State resets to FETCH. illegal resets to 0; instret resets to 0.
- While rst is high, all enables and requests (pc_write, ir_write, mem_read, mem_write, reg_write) are forced 0. All selects are 0.
- Outputs are a combinational decode of state, plus the mem_ready and zero gating listed below. Outputs not listed for a state are 0.
- FETCH: mem_read=1, i_or_d=0, src_a=00, src_b=01, alu_op=00. ir_write=pc_write=mem_ready. On mem_ready go to DECODE, else stay.
- DECODE: src_a=01, src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 with funct3=000 (addi) -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 with funct3=000 (beq) -> BRANCH
  - anything else -> TRAP
- EXEC_R: src_a=10, src_b=00, alu_op=10 -> WB_ALU.
- EXEC_I: src_a=10, src_b=10, alu_op=00 -> WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH; retire.
- MEM_ADDR: src_a=10, src_b=10, alu_op=00. Goes to MEM_RD if opcode=0000011, else MEM_WR. opcode is held stable by IR.
- MEM_RD: mem_read=1, i_or_d=1. Held until mem_ready, then WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1 -> FETCH; retire.
- MEM_WR: mem_write=1, i_or_d=1. Held until mem_ready, then FETCH; retire on that cycle.
- BRANCH: src_a=10, src_b=00, alu_op=01, pc_source=1, pc_write=zero -> FETCH; retire.
- TRAP: all enables 0, illegal=1. Absorbing until rst.
- Retire: instret increments by 1 on the clock edge leaving the retiring state. It wraps from all-ones to 0.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR. Requests stay asserted with a stable address for any number of wait cycles.
- Reset mid-access aborts it: requests drop immediately (asynchronously), and the first post-reset cycle is FETCH.
- Minimum latencies with mem_ready=1, FETCH through return to FETCH: R/addi 4, load 5, store 4, beq 3 cycles.

Decomposition:
- cpu_ctrl_pkg holds:
  - opcode constants: OPC_RTYPE, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH
  - ALUOP_ADD/SUB/RTYPE
  - SRCA_*/SRCB_* encodings
  - 4-bit ST_* state encodings (FETCH=0, TRAP=0xF)
- The alu_op encoding is shared with the ALU control decoder.
- One sub-module, multicycle_ctrl_outdec: purely combinational state -> output decode. The FSM register, illegal flag and instret counter stay in the top.

Test Plan:
- R-type add (opcode 0110011), mem_ready tied 1:
  - FETCH, DECODE, EXEC_R (alu_op=10), WB_ALU (reg_write=1), FETCH.
  - instret 0 -> 1 after 4 cycles.
- Load with mem_ready low for 3 cycles in MEM_RD:
  - mem_read=1 and i_or_d=1 held for 4 cycles.
  - WB_MEM asserts mem_to_reg=1; total 8 cycles FETCH-to-FETCH.
- beq with zero=1, then zero=0:
  - BRANCH alu_op=01, pc_source=1.
  - pc_write=1 in the first case, 0 in the second; instret +1 each.
- Opcode 1111111, or 0010011 with funct3=001:
  - DECODE -> TRAP; illegal=1 and all enables 0 for 20 cycles; instret frozen.
  - rst pulse -> illegal=0, state FETCH.
- rst asserted mid-MEM_WR while mem_ready=0:
  - mem_write drops the same cycle without a clock edge; instret unchanged from pre-reset value reset to 0.
  - After release: FETCH with mem_read=1.
- Preload instret to all-ones (force), then retire a store:
  - instret wraps to 0; mem_write deasserts the cycle after mem_ready.
